// File: rtl/board_io_ctrl_if.sv
// -----------------------------------------------------------------------------
// board_io_ctrl_if
//   Avalon-MM slave bus bundle for the board_io_ctrl component.
//   chipselect/read/write : access strobes (active-high)
//   address               : 3-bit word address
//   writedata             : 32-bit write data
//   readdata              : 32-bit read data, valid one cycle after the read strobe
//   modport master : drives strobes/address/writedata, receives readdata
//   modport slave  : receives strobes/address/writedata, drives readdata
// -----------------------------------------------------------------------------
interface board_io_ctrl_if;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output chipselect,
        output read,
        output write,
        output address,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  read,
        input  write,
        input  address,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/board_io_ctrl.sv
// -----------------------------------------------------------------------------
// board_io_ctrl
//   Avalon-MM slave for DE1-SoC board I/O. Debounces the SW/KEY inputs, latches
//   rising-edge events with a level interrupt, drives the HEX 7-segment digits
//   (hex decode, per-digit enable and blink) and the LEDR outputs.
//
//   clk      in   system clock
//   reset_n  in   asynchronous reset, active-low
//   raw_in   in   asynchronous board inputs (NUM_IN)
//   avs      bus  Avalon-MM slave (chipselect/read/write/address/writedata/readdata)
//   irq      out  level interrupt, active-high
//   hex      out  segments, active-low, digit d = hex[7d+6:7d], bit order gfedcba
//   ledr     out  LED drive, active-high
//
//   Register map (word address):
//     0 STATE RO, 1 EVENTS W1C, 2 IRQ_MASK RW, 3 HEX_VALUE RW,
//     4 HEX_CTRL RW ([7:0] enable, [15:8] blink), 5 LEDR RW, 6/7 read 0.
// -----------------------------------------------------------------------------
module board_io_ctrl #(
    parameter int                NUM_IN          = 14,
    parameter logic [NUM_IN-1:0] ACTIVE_LOW_MASK = 14'h3C00,
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter int                NUM_DIGITS      = 6,
    parameter int                NUM_LEDS        = 10,
    parameter int                BLINK_CYCLES    = 12500000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IN-1:0]       raw_in,
    board_io_ctrl_if.slave          avs,
    output logic                    irq,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic [NUM_LEDS-1:0]     ledr
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int              BL_W    = $clog2(BLINK_CYCLES);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // ---------------------------------------------------------------- state
    logic [NUM_IN-1:0]       sync1_q, sync1_d;
    logic [NUM_IN-1:0]       sync2_q, sync2_d;
    logic [NUM_IN-1:0]       stable_q, stable_d;
    logic [NUM_IN-1:0]       events_q, events_d;
    logic [NUM_IN-1:0]       irq_mask_q, irq_mask_d;
    logic [4*NUM_DIGITS-1:0] hex_value_q, hex_value_d;
    logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
    logic [NUM_DIGITS-1:0]   dig_blink_q, dig_blink_d;
    logic [NUM_LEDS-1:0]     ledr_q, ledr_d;
    logic [31:0]             readdata_q, readdata_d;
    logic                    irq_q, irq_d;
    logic [BL_W-1:0]         blink_cnt_q, blink_cnt_d;
    logic                    phase_q, phase_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

    logic                    wr_en;
    logic                    rd_en;
    logic [NUM_IN-1:0]       rise;
    logic [NUM_IN-1:0]       clr;
    logic [31:0]             rd_mux;

    assign wr_en = avs.chipselect & avs.write;
    assign rd_en = avs.chipselect & avs.read;

    // ---------------------------------------------------------- input path
    // Polarity is normalised before the synchroniser so everything downstream
    // treats 1 as "active".
    always_comb begin
        sync1_d = raw_in ^ ACTIVE_LOW_MASK;
        sync2_d = sync1_q;
    end

    // One debounce counter per channel. The counter only runs while the
    // synchronised input disagrees with the accepted value; any agreement
    // (a glitch returning) restarts it from zero.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IN; gi++) begin : g_db
            logic [DB_W-1:0] cnt_q, cnt_d;
            logic            stable_nx;

            always_comb begin
                cnt_d     = '0;
                stable_nx = stable_q[gi];
                if (sync2_q[gi] != stable_q[gi]) begin
                    if (cnt_q == DB_LAST) begin
                        stable_nx = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stable_d[gi] = stable_nx;
        end
    endgenerate

    assign rise = stable_d & ~stable_q;

    // ------------------------------------------------------ register file
    always_comb begin
        irq_mask_d  = irq_mask_q;
        hex_value_d = hex_value_q;
        dig_en_d    = dig_en_q;
        dig_blink_d = dig_blink_q;
        ledr_d      = ledr_q;
        clr         = '0;

        if (wr_en) begin
            case (avs.address)
                3'd1: clr         = avs.writedata[NUM_IN-1:0];
                3'd2: irq_mask_d  = avs.writedata[NUM_IN-1:0];
                3'd3: hex_value_d = avs.writedata[4*NUM_DIGITS-1:0];
                3'd4: begin
                    dig_en_d    = avs.writedata[NUM_DIGITS-1:0];
                    dig_blink_d = avs.writedata[8 +: NUM_DIGITS];
                end
                3'd5: ledr_d      = avs.writedata[NUM_LEDS-1:0];
                default: ;
            endcase
        end

        // A new rising edge in the same cycle as a clear keeps the flag set.
        events_d = (events_q & ~clr) | rise;
        irq_d    = |(events_q & irq_mask_q);
    end

    always_comb begin
        rd_mux = '0;
        case (avs.address)
            3'd0: rd_mux[NUM_IN-1:0]       = stable_q;
            3'd1: rd_mux[NUM_IN-1:0]       = events_q;
            3'd2: rd_mux[NUM_IN-1:0]       = irq_mask_q;
            3'd3: rd_mux[4*NUM_DIGITS-1:0] = hex_value_q;
            3'd4: begin
                rd_mux[NUM_DIGITS-1:0]  = dig_en_q;
                rd_mux[8 +: NUM_DIGITS] = dig_blink_q;
            end
            3'd5: rd_mux[NUM_LEDS-1:0]     = ledr_q;
            default: ;
        endcase
    end

    // readdata holds between reads; a simultaneous write suppresses the read.
    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            readdata_d = avs.write ? 32'd0 : rd_mux;
        end
    end

    // ------------------------------------------------------------ blinking
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (blink_cnt_q == BL_LAST) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [6:0] seg;
            always_comb begin
                seg = seg7(hex_value_q[4*gi +: 4]);
                if (!dig_en_q[gi] || (dig_blink_q[gi] && phase_q)) begin
                    seg = 7'h7F;
                end
            end
            assign hex_d[7*gi +: 7] = seg;
        end
    endgenerate

    // -------------------------------------------------------------- flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            events_q    <= '0;
            irq_mask_q  <= '0;
            hex_value_q <= '0;
            dig_en_q    <= '0;
            dig_blink_q <= '0;
            ledr_q      <= '0;
            readdata_q  <= '0;
            irq_q       <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            hex_q       <= '1;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stable_q    <= stable_d;
            events_q    <= events_d;
            irq_mask_q  <= irq_mask_d;
            hex_value_q <= hex_value_d;
            dig_en_q    <= dig_en_d;
            dig_blink_q <= dig_blink_d;
            ledr_q      <= ledr_d;
            readdata_q  <= readdata_d;
            irq_q       <= irq_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            hex_q       <= hex_d;
        end
    end

    assign avs.readdata = readdata_q;
    assign irq          = irq_q;
    assign hex          = hex_q;
    assign ledr         = ledr_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_board_io_ctrl
//   Directed scenarios followed by randomized traffic. A reference model keeps
//   the register contents and derives debounced state from a sliding history
//   of raw input samples; reads push their expected data into a queue which a
//   separate monitor pops when readdata becomes valid.
// -----------------------------------------------------------------------------
module tb_board_io_ctrl;
    localparam int          NI   = 14;
    localparam int          D    = 8;
    localparam int          B    = 4;
    localparam int          ND   = 6;
    localparam int          NL   = 10;
    localparam logic [13:0] AMSK = 14'h3C00;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NI-1:0]     raw_in;
    logic              irq;
    logic [7*ND-1:0]   hex;
    logic [NL-1:0]     ledr;

    board_io_ctrl_if bus();

    board_io_ctrl #(
        .NUM_IN(NI), .ACTIVE_LOW_MASK(AMSK), .DEBOUNCE_CYCLES(D),
        .NUM_DIGITS(ND), .NUM_LEDS(NL), .BLINK_CYCLES(B)
    ) dut (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .avs(bus.slave),
        .irq(irq), .hex(hex), .ledr(ledr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------ reference model
    logic [6:0] seg_tbl [16];
    initial begin
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    end

    logic [NI-1:0]   m_stable, m_ev, m_mask;
    logic [4*ND-1:0] m_hexval;
    logic [ND-1:0]   m_en, m_bl;
    logic [NL-1:0]   m_led;
    logic            m_irq;
    logic [7*ND-1:0] m_hex;
    int              m_k;
    logic [NI-1:0]   hist [$];
    logic [31:0]     exp_q [$];
    logic [2:0]      exp_a [$];

    function automatic logic [31:0] reg_value(input logic [2:0] a);
        case (a)
            3'd0: return 32'(m_stable);
            3'd1: return 32'(m_ev);
            3'd2: return 32'(m_mask);
            3'd3: return 32'(m_hexval);
            3'd4: return (32'(m_bl) << 8) | 32'(m_en);
            3'd5: return 32'(m_led);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [NI-1:0] nst, rise, clr;
        logic          ph, flip;
        if (!reset_n) begin
            m_stable = '0; m_ev = '0; m_mask = '0; m_hexval = '0;
            m_en = '0; m_bl = '0; m_led = '0; m_irq = 1'b0; m_hex = '1;
            m_k = 0;
            hist.delete();
            for (int j = 0; j < D + 3; j++) hist.push_back('0);
        end else begin
            // outputs registered from the pre-edge register contents
            ph = ((m_k / B) % 2) == 1;
            m_k++;
            for (int d = 0; d < ND; d++)
                m_hex[7*d +: 7] = (!m_en[d] || (m_bl[d] && ph)) ? 7'h7F : seg_tbl[m_hexval[4*d +: 4]];
            m_irq = |(m_ev & m_mask);
            if (bus.chipselect && bus.read) begin
                exp_q.push_back(bus.write ? 32'd0 : reg_value(bus.address));
                exp_a.push_back(bus.address);
            end
            // A channel flips once the D samples preceding the last two
            // (synchroniser latency) all show the opposite value.
            hist.push_back(raw_in ^ AMSK);
            if (hist.size() > D + 3) void'(hist.pop_front());
            nst = m_stable;
            for (int i = 0; i < NI; i++) begin
                flip = 1'b1;
                for (int j = 1; j <= D; j++)
                    if (hist[j][i] == m_stable[i]) flip = 1'b0;
                if (flip) nst[i] = ~m_stable[i];
            end
            rise = nst & ~m_stable;
            m_stable = nst;
            clr = '0;
            if (bus.chipselect && bus.write) begin
                case (bus.address)
                    3'd1: clr = bus.writedata[NI-1:0];
                    3'd2: m_mask = bus.writedata[NI-1:0];
                    3'd3: m_hexval = bus.writedata[4*ND-1:0];
                    3'd4: begin m_en = bus.writedata[ND-1:0]; m_bl = bus.writedata[8 +: ND]; end
                    3'd5: m_led = bus.writedata[NL-1:0];
                    default: ;
                endcase
            end
            m_ev = (m_ev & ~clr) | rise;
        end
    end

    // -------------------------------------------------------------- monitor
    logic rd_seen = 1'b0;
    always @(posedge clk) rd_seen <= reset_n && bus.chipselect && bus.read;

    always @(negedge clk) begin
        logic [31:0] e;
        logic [2:0]  a;
        if (!reset_n) begin
            check("reset_readdata", 64'(bus.readdata), 64'd0);
            check("reset_irq", 64'(irq), 64'd0);
            check("reset_ledr", 64'(ledr), 64'd0);
            check("reset_hex", 64'(hex), {22'd0, {ND{7'h7F}}});
        end else begin
            check("irq", 64'(irq), 64'(m_irq));
            check("ledr", 64'(ledr), 64'(m_led));
            check("hex", 64'(hex), 64'(m_hex));
            if (rd_seen) begin
                if (exp_q.size() == 0) begin
                    check("rd_expected_present", 64'd0, 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    a = exp_a.pop_front();
                    $display("read addr=%0d data=%08h expected=%08h", a, bus.readdata, e);
                    check("readdata", 64'(bus.readdata), 64'(e));
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
        bus.address = 3'd0; bus.writedata = 32'd0;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b0;
        bus.address = a; bus.writedata = d;
        step(1);
        bus_idle();
    endtask

    task automatic bus_rd(input logic [2:0] a);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b0;
        bus.address = a;
        step(1);
        bus_idle();
    endtask

    initial begin
        int n12, n7f, b, r;
        bus_idle();
        raw_in = AMSK;           // keys released, switches off
        reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(2);

        // short pulse on SW0 is rejected
        raw_in[0] = 1'b1; step(5); raw_in[0] = 1'b0; step(D + 4);
        bus_rd(3'd0); check("pulse_state", 64'(bus.readdata), 64'd0);
        bus_rd(3'd1); check("pulse_events", 64'(bus.readdata), 64'd0);

        // held input is accepted
        raw_in[0] = 1'b1; step(D + 4);
        bus_rd(3'd0); check("held_state", 64'(bus.readdata), 64'd1);

        // reset in the middle of a debounce; input held through reset
        raw_in[0] = 1'b0; step(D + 4);
        raw_in[0] = 1'b1; step(4);
        reset_n = 1'b0; step(2); reset_n = 1'b1;
        step(D - 1);
        bus_rd(3'd0); check("post_reset_state_early", 64'(bus.readdata), 64'd0);
        step(2);
        bus_rd(3'd0); check("post_reset_state_late", 64'(bus.readdata), 64'd1);
        bus_rd(3'd1); check("post_reset_event", 64'(bus.readdata), 64'd1);

        // KEY0 press raises an interrupt
        bus_wr(3'd2, 32'h400);
        bus_wr(3'd1, 32'hFFFF_FFFF);
        raw_in[10] = 1'b0; step(D + 2);
        check("irq_before", 64'(irq), 64'd0);
        step(1);
        check("irq_raised", 64'(irq), 64'd1);
        bus_rd(3'd1); check("key_event", 64'(bus.readdata), 64'h400);
        bus_rd(3'd0); check("key_state", 64'(bus.readdata), 64'h401);
        bus_wr(3'd1, 32'h400); step(1);
        check("irq_cleared", 64'(irq), 64'd0);
        raw_in[10] = 1'b1; step(D + 4);

        // clear of EVENTS[3] in the same cycle as a new rising edge
        raw_in[3] = 1'b1; step(D + 4);
        raw_in[3] = 1'b0; step(D + 4);
        bus_wr(3'd1, 32'h8);
        raw_in[3] = 1'b1; step(D + 1);
        bus_wr(3'd1, 32'h8);
        bus_rd(3'd1); check("w1c_set_wins", 64'(bus.readdata & 32'h8), 64'h8);

        // hex decode, enable and blink
        bus_wr(3'd3, 32'h0000_00A5);
        bus_wr(3'd4, 32'h0000_0003); step(1);
        check("hex_digit0", 64'(hex[6:0]), 64'h12);
        check("hex_digit1", 64'(hex[13:7]), 64'h08);
        check("hex_digits_off", 64'(hex[41:14]), 64'hFFF_FFFF);
        bus_wr(3'd4, 32'h0000_0103); step(1);
        n12 = 0; n7f = 0;
        for (int c = 0; c < 16; c++) begin
            if (hex[6:0] == 7'h12) n12++;
            if (hex[6:0] == 7'h7F) n7f++;
            step(1);
        end
        check("blink_on_count", 64'(n12), 64'd8);
        check("blink_off_count", 64'(n7f), 64'd8);

        // LEDR and unmapped addresses
        bus_wr(3'd5, 32'h3FF);
        check("ledr_drive", 64'(ledr), 64'h3FF);
        bus_rd(3'd5); check("ledr_read", 64'(bus.readdata), 64'h3FF);
        bus_rd(3'd7); check("addr7_read", 64'(bus.readdata), 64'd0);
        bus_wr(3'd7, 32'hFFFF_FFFF);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b1;
        bus.address = 3'd5; bus.writedata = 32'h155;
        step(1); bus_idle();
        check("rw_readdata", 64'(bus.readdata), 64'd0);
        check("rw_ledr", 64'(ledr), 64'h155);

        // randomized traffic
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                b = $urandom_range(0, NI - 1);
                raw_in[b] = ~raw_in[b];
            end
            r = $urandom_range(0, 9);
            bus.chipselect = ($urandom_range(0, 7) != 0);
            bus.address    = 3'($urandom_range(0, 7));
            bus.writedata  = $urandom;
            bus.read       = (r == 2 || r == 3 || r == 4);
            bus.write      = (r == 0 || r == 1 || r == 4);
            step(1);
            bus_idle();
        end

        step(5);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
